nes_pad_serializer: RTL



---
 rtl/nes_pad_serializer.sv | 102 ++++++++++
 1 files changed

// File: rtl/nes_pad_serializer.sv
// nes_pad_serializer: NES 4021 shift-register emulation fed by a HID button vector
module nes_pad_serializer #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 3,
  parameter int STALE_CYCLES  = 3000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pad_in,
  input  logic       pad_valid,
  input  logic       nes_latch,
  input  logic       nes_clk,
  output logic       nes_data,
  output logic       stale,
  output logic [3:0] shift_cnt
);
  localparam int FW = FILTER_CYCLES > 1 ? $clog2(FILTER_CYCLES) : 1;
  localparam int SW = STALE_CYCLES > 1 ? $clog2(STALE_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
  state_t state, state_n;
  logic [1:0] pin, lvl, lvl_d;
  logic lat_rise, lat_fall, clk_rise;
  logic [7:0] held, shreg, shreg_n;
  logic [SW-1:0] age;
  logic [3:0] cnt_n;
  assign pin = {nes_clk, nes_latch};
  genvar i;
  for (i = 0; i < 2; i++) begin : g_cond
    logic [SYNC_STAGES-1:0] sync;
    logic [FW-1:0] cnt;
    logic q, q_d;
    // synchronize the console pin, then only accept a level that stays put for FILTER_CYCLES samples
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        sync <= '0;
        cnt  <= '0;
        q    <= 1'b0;
        q_d  <= 1'b0;
      end else begin
        sync <= {sync[SYNC_STAGES-2:0], pin[i]};
        q_d  <= q;
        if (sync[SYNC_STAGES-1] == q) cnt <= '0;
        else if (cnt == FW'(FILTER_CYCLES - 1)) begin
          q   <= ~q;
          cnt <= '0;
        end else cnt <= cnt + FW'(1);
      end
    assign lvl[i]   = q;
    assign lvl_d[i] = q_d;
  end
  assign lat_rise = lvl[0] & ~lvl_d[0];
  assign lat_fall = ~lvl[0] & lvl_d[0];
  assign clk_rise = lvl[1] & ~lvl_d[1];
  // hold the latest report; release everything once reports stop arriving
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      held  <= '0;
      age   <= '0;
      stale <= 1'b1;
    end else if (pad_valid) begin
      held  <= pad_in;
      age   <= '0;
      stale <= 1'b0;
    end else if (age == SW'(STALE_CYCLES - 1)) begin
      held  <= '0;
      stale <= 1'b1;
    end else age <= age + SW'(1);
  // latch/shift sequencing; a latch edge always beats a simultaneous clock edge
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    cnt_n   = shift_cnt;
    unique case (state)
      IDLE: state_n = lat_rise ? LOAD : IDLE;
      LOAD: begin
        shreg_n = held;
        cnt_n   = '0;
        state_n = lat_fall ? SHIFT : LOAD;
      end
      SHIFT:
        if (lat_rise) state_n = LOAD;
        else if (clk_rise) begin
          shreg_n = {1'b1, shreg[7:1]};
          cnt_n   = shift_cnt == 4'd8 ? shift_cnt : shift_cnt + 4'd1;
        end
      default: state_n = IDLE;
    endcase
  end
  // state, shift register and the registered active-low serial output
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state     <= IDLE;
      shreg     <= '0;
      shift_cnt <= '0;
      nes_data  <= 1'b1;
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      shift_cnt <= cnt_n;
      nes_data  <= ~shreg[0];
    end
endmodule
